// File: rtl/dc_ipu_array_divider_pkg.sv
// Shared constants and helpers for the lane-parallel programmable delay line.
package dc_ipu_array_divider_pkg;

    // Width of a length value able to hold 0..max_length inclusive.
    function automatic int unsigned calc_lw(input int unsigned max_length);
        return $clog2(max_length + 1);
    endfunction

    // Width of a tap index selecting one of max_length stages.
    function automatic int unsigned calc_iw(input int unsigned max_length);
        return (max_length > 1) ? $clog2(max_length) : 1;
    endfunction

    // LSB position of a lane inside a flattened lane bus (lane 0 in the LSBs).
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
        return lane * width;
    endfunction

endpackage

// File: rtl/dc_ipu_array_divider_delay_stage.sv
// One delay-line stage: enabled {data, valid} register whose valid bit can be cleared
// without disturbing the data bits.
module dc_ipu_array_divider_delay_stage
    import dc_ipu_array_divider_pkg::*;
#(
    parameter int unsigned DW = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          clr,
    input  logic [DW-1:0] i_data,
    input  logic          i_valid,
    output logic [DW-1:0] o_data,
    output logic          o_valid
);

    logic [DW-1:0] r_data;
    logic          r_valid;

    // Reset wins, then clear (valid only), then the enabled shift.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (clr) begin
            r_valid <= 1'b0;
        end else if (en) begin
            r_data  <= i_data;
            r_valid <= i_valid;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/dc_ipu_array_divider_delay_line.sv
// Lane-parallel delay line with a runtime-selectable length shared by all lanes.
// The output is tapped combinationally from stage len_r-1 of a MAX_LENGTH-deep chain.
module dc_ipu_array_divider_delay_line
    import dc_ipu_array_divider_pkg::*;
#(
    parameter  int unsigned WIDTH      = 16,
    parameter  int unsigned LANES      = 4,
    parameter  int unsigned MAX_LENGTH = 16,
    localparam int unsigned LW         = calc_lw(MAX_LENGTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   load,
    input  logic [LW-1:0]          len,
    input  logic                   flush,
    input  logic                   in_valid,
    input  logic [LANES*WIDTH-1:0] d,
    output logic [LANES*WIDTH-1:0] q,
    output logic                   out_valid,
    output logic                   primed,
    output logic                   len_err
);

    localparam int unsigned DW = LANES * WIDTH;
    localparam int unsigned IW = calc_iw(MAX_LENGTH);

    logic [LW-1:0] r_len;
    logic [LW-1:0] r_prime_cnt;
    logic          r_len_err;

    logic          w_clr;
    logic          w_shift;
    logic [LW-1:0] w_len_clamped;
    logic          w_len_illegal;
    logic [IW-1:0] w_tap_idx;
    logic [DW-1:0] w_stage_d [MAX_LENGTH];
    logic          w_stage_v [MAX_LENGTH];
    logic [DW-1:0] w_tap_d;

    // Load and flush both invalidate the pipe and suppress the shift on that cycle.
    assign w_clr   = load | flush;
    assign w_shift = en & ~w_clr;

    // Stage chain: stage 0 takes the input, every later stage takes its predecessor.
    for (genvar i = 0; i < MAX_LENGTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            dc_ipu_array_divider_delay_stage #(.DW(DW)) u_stage (
                .clk     (clk),
                .reset   (reset),
                .en      (w_shift),
                .clr     (w_clr),
                .i_data  (d),
                .i_valid (in_valid),
                .o_data  (w_stage_d[i]),
                .o_valid (w_stage_v[i])
            );
        end else begin : g_body
            dc_ipu_array_divider_delay_stage #(.DW(DW)) u_stage (
                .clk     (clk),
                .reset   (reset),
                .en      (w_shift),
                .clr     (w_clr),
                .i_data  (w_stage_d[i-1]),
                .i_valid (w_stage_v[i-1]),
                .o_data  (w_stage_d[i]),
                .o_valid (w_stage_v[i])
            );
        end
    end

    // Clamp a requested length into 1..MAX_LENGTH and flag when clamping was needed.
    always_comb begin
        w_len_clamped = len;
        w_len_illegal = 1'b0;
        if (len == '0) begin
            w_len_clamped = LW'(1);
            w_len_illegal = 1'b1;
        end else if (len > LW'(MAX_LENGTH)) begin
            w_len_clamped = LW'(MAX_LENGTH);
            w_len_illegal = 1'b1;
        end
    end

    // Active length and sticky length-error flag, updated only by load.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_len     <= LW'(MAX_LENGTH);
            r_len_err <= 1'b0;
        end else if (load) begin
            r_len     <= w_len_clamped;
            r_len_err <= w_len_illegal;
        end
    end

    // Prime counter: counts enabled shifts since the last clear, saturating at the active length.
    always_ff @(posedge clk) begin
        if (reset || w_clr) begin
            r_prime_cnt <= '0;
        end else if (w_shift && (r_prime_cnt != r_len)) begin
            r_prime_cnt <= r_prime_cnt + LW'(1);
        end
    end

    // Single shared tap mux; r_len is never zero so the index stays in range.
    assign w_tap_idx = IW'(r_len - LW'(1));
    assign w_tap_d   = w_stage_d[w_tap_idx];
    assign out_valid = w_stage_v[w_tap_idx];

    // Lane-wise output assembly from the selected stage.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        localparam int unsigned LSB = lane_lsb(l, WIDTH);
        assign q[LSB +: WIDTH] = w_tap_d[LSB +: WIDTH];
    end

    assign primed  = (r_prime_cnt == r_len);
    assign len_err = r_len_err;

endmodule

// File: tb/tb_dc_ipu_array_divider_delay_line.sv
// Self-checking bench for the lane-parallel delay line: directed scenarios with
// literal expectations plus randomized traffic against a shift-log reference model.
`timescale 1ns/1ps
module tb_dc_ipu_array_divider_delay_line;

    localparam int unsigned WIDTH      = 16;
    localparam int unsigned LANES      = 4;
    localparam int unsigned MAX_LENGTH = 16;
    localparam int unsigned LW         = $clog2(MAX_LENGTH + 1);
    localparam int unsigned DW         = WIDTH * LANES;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic          load;
    logic [LW-1:0] len;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] d;
    logic [DW-1:0] q;
    logic          out_valid;
    logic          primed;
    logic          len_err;

    dc_ipu_array_divider_delay_line #(
        .WIDTH      (WIDTH),
        .LANES      (LANES),
        .MAX_LENGTH (MAX_LENGTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .load      (load),
        .len       (len),
        .flush     (flush),
        .in_valid  (in_valid),
        .d         (d),
        .q         (q),
        .out_valid (out_valid),
        .primed    (primed),
        .len_err   (len_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    // Reference model: a log of every accepted shift. The output is the entry written
    // len_r shifts ago; it is valid only if it was written after the last clear point.
    logic [DW-1:0] m_d [$];
    bit            m_v [$];
    int            m_clr;
    int            m_len;
    bit            m_err;

    function automatic void model_reset();
        m_d.delete();
        m_v.delete();
        for (int i = 0; i < int'(MAX_LENGTH); i++) begin
            m_d.push_back('0);
            m_v.push_back(1'b0);
        end
        m_clr = int'(MAX_LENGTH);
        m_len = int'(MAX_LENGTH);
        m_err = 1'b0;
    endfunction

    function automatic void model_edge();
        int r;
        r = int'(len);
        if (reset) begin
            model_reset();
        end else if (load) begin
            m_err = (r == 0) || (r > int'(MAX_LENGTH));
            m_len = (r == 0) ? 1 : ((r > int'(MAX_LENGTH)) ? int'(MAX_LENGTH) : r);
            m_clr = m_d.size();
        end else if (flush) begin
            m_clr = m_d.size();
        end else if (en) begin
            m_d.push_back(d);
            m_v.push_back(in_valid);
        end
    endfunction

    function automatic logic [DW-1:0] exp_q();
        return m_d[m_d.size() - m_len];
    endfunction

    function automatic bit exp_v();
        int idx;
        idx = m_d.size() - m_len;
        return (idx >= m_clr) && m_v[idx];
    endfunction

    function automatic bit exp_primed();
        return (m_d.size() - m_clr) >= m_len;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of all outputs against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            check("q",         q,              exp_q());
            check("out_valid", DW'(out_valid), DW'(exp_v()));
            check("primed",    DW'(primed),    DW'(exp_primed()));
            check("len_err",   DW'(len_err),   DW'(m_err));
        end
    end

    // One clock: the model sees the same inputs the DUT samples, then inputs may change.
    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    function automatic logic [DW-1:0] rnd_d();
        return {$urandom(), $urandom()};
    endfunction

    logic [DW-1:0] mark;

    initial begin
        reset = 1'b1; en = 1'b0; load = 1'b0; flush = 1'b0;
        in_valid = 1'b0; len = '0; d = '0;
        model_reset();
        cyc();
        cyc();
        chk_on = 1'b1;
        reset  = 1'b0;

        // Reset state.
        check("rst_q",         q,              '0);
        check("rst_out_valid", DW'(out_valid), '0);
        check("rst_primed",    DW'(primed),    '0);
        check("rst_len_err",   DW'(len_err),   '0);

        // Length 3, single valid sample with lane values 1..4.
        load = 1'b1; len = LW'(3); cyc(); load = 1'b0;
        en = 1'b1; in_valid = 1'b1; d = {16'd4, 16'd3, 16'd2, 16'd1}; cyc();
        in_valid = 1'b0; d = rnd_d(); cyc();
        check("l3_early_valid",  DW'(out_valid), '0);
        check("l3_early_primed", DW'(primed),    '0);
        d = rnd_d(); cyc();
        check("l3_valid",  DW'(out_valid), DW'(1'b1));
        check("l3_q",      q,              64'h0004_0003_0002_0001);
        check("l3_primed", DW'(primed),    DW'(1'b1));
        d = rnd_d(); cyc();
        check("l3_after_valid", DW'(out_valid), '0);

        // Length 5 with en toggling: 5 enabled edges span 9 clocks.
        en = 1'b0; load = 1'b1; len = LW'(5); cyc(); load = 1'b0;
        mark = 64'hA5A5_1234_0F0F_BEEF;
        for (int e = 1; e <= 9; e++) begin
            en       = (e % 2 == 1);
            in_valid = (e == 1);
            d        = (e == 1) ? mark : rnd_d();
            cyc();
            if (e == 8) check("l5_edge8_valid", DW'(out_valid), '0);
        end
        check("l5_valid", DW'(out_valid), DW'(1'b1));
        check("l5_q",     q,              mark);
        en = 1'b0; in_valid = 1'b1; d = rnd_d(); cyc(); cyc();
        check("l5_hold_q",     q,              mark);
        check("l5_hold_valid", DW'(out_valid), DW'(1'b1));

        // Length clamping and the sticky error flag.
        in_valid = 1'b0;
        load = 1'b1; len = LW'(0); cyc(); load = 1'b0;
        check("len0_err", DW'(len_err), DW'(1'b1));
        mark = 64'h1111_2222_3333_4444;
        en = 1'b1; in_valid = 1'b1; d = mark; cyc();
        check("len0_lat1_valid", DW'(out_valid), DW'(1'b1));
        check("len0_lat1_q",     q,              mark);
        en = 1'b0; in_valid = 1'b0;
        load = 1'b1; len = LW'(20); cyc(); load = 1'b0;
        check("len20_err", DW'(len_err), DW'(1'b1));
        cyc();
        check("len20_err_hold", DW'(len_err), DW'(1'b1));
        load = 1'b1; len = LW'(4); cyc(); load = 1'b0;
        check("len4_err", DW'(len_err), '0);

        // Flush of a full pipe at length 4.
        en = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin d = rnd_d(); cyc(); end
        check("full_valid",  DW'(out_valid), DW'(1'b1));
        check("full_primed", DW'(primed),    DW'(1'b1));
        flush = 1'b1; d = 64'hDEAD_DEAD_DEAD_DEAD; cyc(); flush = 1'b0;
        check("flush_valid",  DW'(out_valid), '0);
        check("flush_primed", DW'(primed),    '0);
        in_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            d = rnd_d(); cyc();
            check("post_flush_valid",  DW'(out_valid), '0);
            check("post_flush_primed", DW'(primed),    DW'(i == 4));
        end

        // Reset coincident with load, on a full pipe at length 8.
        load = 1'b1; len = LW'(8); cyc(); load = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin d = rnd_d(); cyc(); end
        check("l8_full_valid", DW'(out_valid), DW'(1'b1));
        reset = 1'b1; load = 1'b1; len = LW'(2); cyc(); reset = 1'b0; load = 1'b0;
        check("rl_q",         q,              '0);
        check("rl_out_valid", DW'(out_valid), '0);
        check("rl_primed",    DW'(primed),    '0);
        check("rl_len_err",   DW'(len_err),   '0);
        mark = 64'h0123_4567_89AB_CDEF;
        for (int i = 1; i <= 16; i++) begin
            in_valid = (i == 1);
            d        = (i == 1) ? mark : rnd_d();
            cyc();
            if (i == 15) check("rl_len16_early", DW'(out_valid), '0);
        end
        check("rl_len16_valid", DW'(out_valid), DW'(1'b1));
        check("rl_len16_q",     q,              mark);

        // Long random in_valid run at length 16.
        load = 1'b1; len = LW'(16); en = 1'b1; cyc(); load = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            d        = rnd_d();
            cyc();
        end

        // Fully random control mix.
        for (int i = 0; i < 400; i++) begin
            reset    = ($urandom_range(0, 99) == 0);
            load     = ($urandom_range(0, 19) == 0);
            flush    = ($urandom_range(0, 19) == 0);
            en       = 1'($urandom_range(0, 1));
            in_valid = 1'($urandom_range(0, 1));
            len      = LW'($urandom_range(0, 31));
            d        = rnd_d();
            cyc();
        end
        reset = 1'b0; load = 1'b0; flush = 1'b0; en = 1'b0;
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
